// File: rtl/fifo.sv
// Single-clock first-word-fall-through byte FIFO with occupancy count and
// registered one-cycle overflow/underflow pulses for rejected requests.
module fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             enqueue,
  input  logic             dequeue,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push
  // when it is also popping; an empty FIFO never passes data through.
  assign w_do_pop  = dequeue & ~empty;
  assign w_do_push = enqueue & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst && w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= enqueue & ~w_do_push;
      r_underflow <= dequeue & empty;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed plan plus randomized traffic against a queue-based model of the FIFO.
module tb_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             enqueue;
  logic             dequeue;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .din(din), .enqueue(enqueue), .dequeue(dequeue),
    .dout(dout), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] q[$];
  logic             m_ov, m_un;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: a bounded queue; pop happens before push so a full
  // queue can accept a push in the same cycle it pops.
  task automatic model(input logic r, input logic e, input logic d, input logic [WIDTH-1:0] data);
    bit pop, push;
    if (r) begin
      q.delete();
      m_ov = 0;
      m_un = 0;
    end else begin
      pop  = d && (q.size() > 0);
      push = e && (q.size() < DEPTH || pop);
      m_ov = e && !push;
      m_un = d && (q.size() == 0);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(data);
    end
  endtask

  task automatic check_all();
    chk("count",     32'(count),     32'(q.size()));
    chk("empty",     32'(empty),     32'(q.size() == 0));
    chk("full",      32'(full),      32'(q.size() == DEPTH));
    chk("dout",      32'(dout),      (q.size() == 0) ? 32'd0 : 32'(q[0]));
    chk("overflow",  32'(overflow),  32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_un));
  endtask

  task automatic step(input logic r, input logic e, input logic d, input logic [WIDTH-1:0] data);
    rst = r; enqueue = e; dequeue = d; din = data;
    @(posedge clk);
    model(r, e, d, data);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; enqueue = 1'b0; dequeue = 1'b0; din = '0;
    #2;

    // reset
    step(1, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    // back-to-back push then combined push/pop then drain past empty
    step(0, 1, 0, 8'd9);
    repeat (3) step(0, 1, 0, 8'd8);
    step(0, 1, 1, 8'd8);
    repeat (8) step(0, 0, 1, 8'd0);
    step(0, 0, 0, 8'd0);

    // fill, overflow, drain, wrap
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(i));
    step(0, 1, 0, 8'hEE);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'hA5);
    step(0, 1, 0, 8'h5A);
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);

    // full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(8'h40 + i));
    step(0, 1, 1, 8'h77);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'h00);

    // empty with simultaneous push and pop
    step(0, 1, 1, 8'h33);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);

    // reset mid-operation overrides a concurrent push
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h90 + i));
    step(1, 1, 0, 8'hC3);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);

    // randomized traffic with phases biased toward filling and draining
    for (int i = 0; i < 3000; i++) begin
      int pe;
      pe = ((i / 200) % 2 == 0) ? 75 : 25;
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < pe),
           ($urandom_range(0, 99) < (100 - pe)),
           8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
